// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bus: stage hazard fields in, forwarding/stall/flush/run-state out.
interface pipeline_hazard_ctrl_if;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic       d_use_rs1;
  logic       d_use_rs2;
  logic [4:0] e_rd;
  logic       e_rf_wr_en;
  logic       e_is_load;
  logic       e_redirect;
  logic [4:0] m_rd;
  logic       m_rf_wr_en;
  logic       m_dmem_req;
  logic       dmem_ready;
  logic       w_ecall;
  logic       resume;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       halted;
  logic       mem_fault;

  modport master (
    output d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_rf_wr_en, e_is_load, e_redirect,
    output m_rd, m_rf_wr_en, m_dmem_req, dmem_ready, w_ecall, resume,
    input  fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, halted, mem_fault
  );

  modport slave (
    input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_rf_wr_en, e_is_load, e_redirect,
    input  m_rd, m_rf_wr_en, m_dmem_req, dmem_ready, w_ecall, resume,
    output fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, halted, mem_fault
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, stalls, flushes, run/halt FSM.
// Optional macro PERF_CNT_EN adds saturating stall/flush/mem-wait performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave hz
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_mem_wait_cyc
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
    $error("pipeline_hazard_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_fault_q, fault_set;
  logic       mem_hold, load_use, redirect_flush;

  // E-stage results are only forwardable for non-loads; load data arrives one stage later.
  always_comb begin
    hz.fwd_a = 2'b00;
    hz.fwd_b = 2'b00;
    if (hz.e_rf_wr_en && hz.e_rd != 5'd0 && hz.e_rd == hz.d_rs1 && !hz.e_is_load)
      hz.fwd_a = 2'b01;
    else if (hz.m_rf_wr_en && hz.m_rd != 5'd0 && hz.m_rd == hz.d_rs1)
      hz.fwd_a = 2'b10;
    if (hz.e_rf_wr_en && hz.e_rd != 5'd0 && hz.e_rd == hz.d_rs2 && !hz.e_is_load)
      hz.fwd_b = 2'b01;
    else if (hz.m_rf_wr_en && hz.m_rd != 5'd0 && hz.m_rd == hz.d_rs2)
      hz.fwd_b = 2'b10;
  end

  assign load_use = hz.e_is_load && hz.e_rf_wr_en && hz.e_rd != 5'd0 &&
                    ((hz.d_use_rs1 && hz.e_rd == hz.d_rs1) ||
                     (hz.d_use_rs2 && hz.e_rd == hz.d_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_fault_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (fault_set)
        mem_fault_q <= 1'b1;
    end
  end

  // A completing access (ready in MEM_WAIT) releases the pipeline, so deferred redirect/lu act then.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    fault_set      = 1'b0;
    mem_hold       = 1'b0;
    redirect_flush = 1'b0;
    hz.stall_f     = 1'b0;
    hz.stall_d     = 1'b0;
    hz.stall_e     = 1'b0;
    hz.stall_m     = 1'b0;
    hz.flush_d     = 1'b0;
    hz.flush_e     = 1'b0;
    case (state)
      RUN: begin
        mem_hold = hz.m_dmem_req && !hz.dmem_ready;
        if (hz.w_ecall) begin
          state_nxt = HALTED;
        end else if (mem_hold) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        mem_hold = !hz.dmem_ready;
        if (hz.dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt    = HALTED;
          wait_cnt_nxt = 8'd0;
          fault_set    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      HALTED: begin
        hz.stall_f = 1'b1;
        hz.flush_d = 1'b1;
        hz.flush_e = 1'b1;
        if (hz.resume && !mem_fault_q)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    if (state != HALTED) begin
      if (mem_hold) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.stall_m = 1'b1;
      end else if (hz.e_redirect) begin
        hz.flush_d     = 1'b1;
        hz.flush_e     = 1'b1;
        redirect_flush = 1'b1;
      end else if (load_use) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end
    end
  end

  assign hz.halted    = (state == HALTED);
  assign hz.mem_fault = mem_fault_q;

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters saturate rather than wrap so long runs never report a misleadingly small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc    <= '0;
      perf_flush_cnt    <= '0;
      perf_mem_wait_cyc <= '0;
    end else begin
      if (hz.stall_f && state != HALTED && perf_stall_cyc != CNT_MAX)
        perf_stall_cyc <= perf_stall_cyc + CNT_ONE;
      if (redirect_flush && perf_flush_cnt != CNT_MAX)
        perf_flush_cnt <= perf_flush_cnt + CNT_ONE;
      if (state == MEM_WAIT && perf_mem_wait_cyc != CNT_MAX)
        perf_mem_wait_cyc <= perf_mem_wait_cyc + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed plan cases then randomized traffic vs a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic       d_use_rs1;
    logic       d_use_rs2;
    logic [4:0] e_rd;
    logic       e_rf_wr_en;
    logic       e_is_load;
    logic       e_redirect;
    logic [4:0] m_rd;
    logic       m_rf_wr_en;
    logic       m_dmem_req;
    logic       dmem_ready;
    logic       w_ecall;
    logic       resume;
  } stim_t;

  typedef struct {
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       halted;
    logic       mem_fault;
    longint     p_stall;
    longint     p_flush;
    longint     p_wait;
  } expect_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  expect_t exp_q[$];

  // Reference model: architectural view of the controller (halted / waiting / fault flags).
  bit     mdl_halted;
  bit     mdl_waiting;
  bit     mdl_fault;
  int     mdl_wait_len;
  longint mdl_p_stall;
  longint mdl_p_flush;
  longint mdl_p_wait;

  pipeline_hazard_ctrl_if hif ();

`ifdef PERF_CNT_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_mem_wait_cyc;
`endif

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hif)
`ifdef PERF_CNT_EN
    ,
    .perf_stall_cyc   (perf_stall_cyc),
    .perf_flush_cnt   (perf_flush_cnt),
    .perf_mem_wait_cyc(perf_mem_wait_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.d_rs1 = 5'd0; s.d_rs2 = 5'd0; s.d_use_rs1 = 1'b0; s.d_use_rs2 = 1'b0;
    s.e_rd = 5'd0; s.e_rf_wr_en = 1'b0; s.e_is_load = 1'b0; s.e_redirect = 1'b0;
    s.m_rd = 5'd0; s.m_rf_wr_en = 1'b0; s.m_dmem_req = 1'b0; s.dmem_ready = 1'b1;
    s.w_ecall = 1'b0; s.resume = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (s.e_rf_wr_en && s.e_rd != 0 && s.e_rd == rs && !s.e_is_load) return 2'b01;
    if (s.m_rf_wr_en && s.m_rd != 0 && s.m_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit blocked_by_mem(input stim_t s);
    if (mdl_waiting) return !s.dmem_ready;
    return s.m_dmem_req && !s.dmem_ready;
  endfunction

  function automatic expect_t predict(input stim_t s);
    expect_t e;
    bit lu;
    lu = s.e_is_load && s.e_rf_wr_en && s.e_rd != 0 &&
         ((s.d_use_rs1 && s.e_rd == s.d_rs1) || (s.d_use_rs2 && s.e_rd == s.d_rs2));
    e.fwd_a = ref_fwd(s.d_rs1, s);
    e.fwd_b = ref_fwd(s.d_rs2, s);
    {e.stall_f, e.stall_d, e.stall_e, e.stall_m, e.flush_d, e.flush_e} = 6'b0;
    if (mdl_halted) begin
      e.stall_f = 1; e.flush_d = 1; e.flush_e = 1;
    end else if (blocked_by_mem(s)) begin
      e.stall_f = 1; e.stall_d = 1; e.stall_e = 1; e.stall_m = 1;
    end else if (s.e_redirect) begin
      e.flush_d = 1; e.flush_e = 1;
    end else if (lu) begin
      e.stall_f = 1; e.stall_d = 1; e.flush_e = 1;
    end
    e.halted    = mdl_halted;
    e.mem_fault = mdl_fault;
    e.p_stall   = mdl_p_stall;
    e.p_flush   = mdl_p_flush;
    e.p_wait    = mdl_p_wait;
    return e;
  endfunction

  task automatic advanceModel(input stim_t s, input expect_t e);
    bit blk;
    blk = blocked_by_mem(s);
    if (e.stall_f && !mdl_halted) mdl_p_stall = mdl_p_stall + 1;
    if (!mdl_halted && !blk && s.e_redirect) mdl_p_flush = mdl_p_flush + 1;
    if (mdl_waiting) mdl_p_wait = mdl_p_wait + 1;
    if (mdl_halted) begin
      if (s.resume && !mdl_fault) mdl_halted = 0;
    end else if (mdl_waiting) begin
      if (s.dmem_ready) mdl_waiting = 0;
      else if (mdl_wait_len == TIMEOUT) begin
        mdl_waiting = 0; mdl_halted = 1; mdl_fault = 1;
      end else mdl_wait_len++;
    end else if (s.w_ecall) begin
      mdl_halted = 1;
    end else if (s.m_dmem_req && !s.dmem_ready) begin
      mdl_waiting = 1; mdl_wait_len = 1;
    end
  endtask

  task automatic drive(input stim_t s);
    hif.d_rs1 = s.d_rs1; hif.d_rs2 = s.d_rs2;
    hif.d_use_rs1 = s.d_use_rs1; hif.d_use_rs2 = s.d_use_rs2;
    hif.e_rd = s.e_rd; hif.e_rf_wr_en = s.e_rf_wr_en;
    hif.e_is_load = s.e_is_load; hif.e_redirect = s.e_redirect;
    hif.m_rd = s.m_rd; hif.m_rf_wr_en = s.m_rf_wr_en;
    hif.m_dmem_req = s.m_dmem_req; hif.dmem_ready = s.dmem_ready;
    hif.w_ecall = s.w_ecall; hif.resume = s.resume;
  endtask

  // Called at posedge+1: drive one cycle of inputs, queue the expected response, step the model.
  task automatic applyStimulus(input stim_t s);
    expect_t e;
    drive(s);
    e = predict(s);
    exp_q.push_back(e);
    advanceModel(s, e);
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted mid-cycle so the following negedge sample shows its asynchronous effect.
  task automatic applyReset();
    expect_t e;
    drive(idle());
    rst_n = 1'b0;
    mdl_halted = 0; mdl_waiting = 0; mdl_fault = 0; mdl_wait_len = 0;
    mdl_p_stall = 0; mdl_p_flush = 0; mdl_p_wait = 0;
    e = predict(idle());
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    chk("fwd_a", longint'(hif.fwd_a), longint'(e.fwd_a));
    chk("fwd_b", longint'(hif.fwd_b), longint'(e.fwd_b));
    chk("stall_f", longint'(hif.stall_f), longint'(e.stall_f));
    chk("stall_d", longint'(hif.stall_d), longint'(e.stall_d));
    chk("stall_e", longint'(hif.stall_e), longint'(e.stall_e));
    chk("stall_m", longint'(hif.stall_m), longint'(e.stall_m));
    chk("flush_d", longint'(hif.flush_d), longint'(e.flush_d));
    chk("flush_e", longint'(hif.flush_e), longint'(e.flush_e));
    chk("halted", longint'(hif.halted), longint'(e.halted));
    chk("mem_fault", longint'(hif.mem_fault), longint'(e.mem_fault));
`ifdef PERF_CNT_EN
    chk("perf_stall_cyc", longint'(perf_stall_cyc), e.p_stall);
    chk("perf_flush_cnt", longint'(perf_flush_cnt), e.p_flush);
    chk("perf_mem_wait_cyc", longint'(perf_mem_wait_cyc), e.p_wait);
`endif
  endtask

  // Monitor: the DUT presents a response every cycle; compare it on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    int    faulted_cycles;
    checks = 0;
    errors = 0;
    faulted_cycles = 0;
    rst_n = 1'b0;
    drive(idle());
    @(posedge clk);
    #1;
    applyReset();

    // Forwarding: E match, M-only match, both, rd = 0.
    s = idle(); s.e_rd = 5; s.e_rf_wr_en = 1; s.d_rs1 = 5; s.d_use_rs1 = 1;
    applyStimulus(s);
    s = idle(); s.m_rd = 5; s.m_rf_wr_en = 1; s.d_rs1 = 5; s.d_use_rs1 = 1;
    applyStimulus(s);
    s.e_rd = 5; s.e_rf_wr_en = 1;
    applyStimulus(s);
    s.e_rd = 0; s.m_rd = 0; s.d_rs1 = 0;
    applyStimulus(s);

    // Load-use on rs2, then the load has moved to M.
    s = idle(); s.e_rd = 7; s.e_rf_wr_en = 1; s.e_is_load = 1; s.d_rs2 = 7; s.d_use_rs2 = 1;
    applyStimulus(s);
    s = idle(); s.m_rd = 7; s.m_rf_wr_en = 1; s.d_rs2 = 7; s.d_use_rs2 = 1;
    applyStimulus(s);

    // Load-use and redirect together.
    s = idle(); s.e_rd = 7; s.e_rf_wr_en = 1; s.e_is_load = 1; s.d_rs1 = 7; s.d_use_rs1 = 1;
    s.e_redirect = 1;
    applyStimulus(s);

    // Three not-ready cycles then ready.
    s = idle(); s.m_dmem_req = 1; s.dmem_ready = 0;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.dmem_ready = 1;
    applyStimulus(s);
    applyStimulus(idle());

    // Timeout into fault; resume must be ignored.
    s = idle(); s.m_dmem_req = 1; s.dmem_ready = 0;
    for (int i = 0; i < 6; i++) applyStimulus(s);
    s = idle(); s.resume = 1;
    applyStimulus(s);
    applyStimulus(idle());
    applyReset();

    // Reset in the middle of a memory wait.
    s = idle(); s.m_dmem_req = 1; s.dmem_ready = 0;
    for (int i = 0; i < 2; i++) applyStimulus(s);
    applyReset();
    applyStimulus(idle());

    // ECALL halt and resume.
    s = idle(); s.w_ecall = 1;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());
    s = idle(); s.resume = 1;
    applyStimulus(s);
    applyStimulus(idle());

    // Randomized traffic with narrow register ranges to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0 || faulted_cycles > 10) begin
        applyReset();
        faulted_cycles = 0;
      end else begin
        s.d_rs1      = 5'($urandom_range(0, 3));
        s.d_rs2      = 5'($urandom_range(0, 3));
        s.d_use_rs1  = 1'($urandom_range(0, 1));
        s.d_use_rs2  = 1'($urandom_range(0, 1));
        s.e_rd       = 5'($urandom_range(0, 3));
        s.e_rf_wr_en = ($urandom_range(0, 3) != 0);
        s.e_is_load  = ($urandom_range(0, 3) == 0);
        s.e_redirect = ($urandom_range(0, 7) == 0);
        s.m_rd       = 5'($urandom_range(0, 3));
        s.m_rf_wr_en = ($urandom_range(0, 3) != 0);
        s.m_dmem_req = ($urandom_range(0, 3) == 0);
        s.dmem_ready = ($urandom_range(0, 9) < 6);
        s.w_ecall    = ($urandom_range(0, 31) == 0);
        s.resume     = ($urandom_range(0, 7) == 0);
        if (mdl_fault) faulted_cycles++;
        applyStimulus(s);
      end
    end

    drive(idle());
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
